// File: rtl/wts_adsr_pkg.sv
// Shared types for the time-multiplexed ADSR envelope generator:
// the envelope phase encoding and the key-event ranking.
package wts_adsr_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4,
    ST_HOLD    = 3'd5
  } adsr_state_e;

  // Key events ranked so that a numerically larger code wins a slot.
  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_RELEASE = 2'd1,
    EV_ON      = 2'd2,
    EV_OFF     = 2'd3
  } adsr_event_e;

  // Reduce the three flags of one channel to the single event acted on.
  function automatic adsr_event_e pick_event(input logic on, input logic rel, input logic off);
    if (off) return EV_OFF;
    if (on)  return EV_ON;
    if (rel) return EV_RELEASE;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/wts_adsr_envelope_generator_nch_if.sv
// Channel-slot bus of the envelope generator: slot select, key pulses,
// per-channel rate registers and the tagged envelope output.
interface wts_adsr_envelope_generator_nch_if #(
  parameter int CH    = 5,
  parameter int IDX_W = 3,
  parameter int LVL_W = 7
);
  logic [IDX_W-1:0]    active;
  logic                adsr_en;
  logic [CH-1:0]       key_on;
  logic [CH-1:0]       key_release;
  logic [CH-1:0]       key_off;
  logic [CH*8-1:0]     reg_ar;
  logic [CH*8-1:0]     reg_dr;
  logic [CH*8-1:0]     reg_sr;
  logic [CH*8-1:0]     reg_rr;
  logic [CH*8-1:0]     reg_hold;
  logic [CH*LVL_W-1:0] reg_sl;
  logic [LVL_W-1:0]    envelope;
  logic [IDX_W-1:0]    envelope_ch;
  logic                envelope_vld;

  modport master (
    output active, adsr_en, key_on, key_release, key_off,
    output reg_ar, reg_dr, reg_sr, reg_rr, reg_hold, reg_sl,
    input  envelope, envelope_ch, envelope_vld
  );

  modport slave (
    input  active, adsr_en, key_on, key_release, key_off,
    input  reg_ar, reg_dr, reg_sr, reg_rr, reg_hold, reg_sl,
    output envelope, envelope_ch, envelope_vld
  );
endinterface

// File: rtl/wts_adsr_step.sv
// Single-channel envelope update: given one channel's phase, phase
// counter, level and the winning key event, produce its next values.
module wts_adsr_step
  import wts_adsr_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int LVL_W      = 7,
  parameter int HOLD_SHIFT = 8,
  parameter int RETRIG     = 0
) (
  input  adsr_state_e      state,
  input  logic [CNT_W-1:0] counter,
  input  logic [LVL_W-1:0] level,
  input  adsr_event_e      ev,
  input  logic             adsr_en,
  input  logic [7:0]       ar,
  input  logic [7:0]       dr,
  input  logic [7:0]       sr,
  input  logic [7:0]       rr,
  input  logic [7:0]       hold,
  input  logic [LVL_W-1:0] sl,
  output adsr_state_e      state_next,
  output logic [CNT_W-1:0] counter_next,
  output logic [LVL_W-1:0] level_next
);

  localparam logic [LVL_W-1:0] LVL_MAX = '1;
  // Wide enough for both the shifted hold length and the phase counter.
  localparam int HL_W = (((8 + HOLD_SHIFT) > CNT_W) ? (8 + HOLD_SHIFT) : CNT_W) + 1;

  logic [7:0]       rate;
  logic [CNT_W:0]   sum;
  logic             step;
  logic [LVL_W-1:0] level_up;
  logic [LVL_W-1:0] level_dn;
  logic [LVL_W-1:0] decayed;
  logic [HL_W-1:0]  hold_last;

  // Rate of the current phase; IDLE and HOLD never take a rate step.
  always_comb begin
    case (state)
      ST_ATTACK:  rate = ar;
      ST_DECAY:   rate = dr;
      ST_SUSTAIN: rate = sr;
      ST_RELEASE: rate = rr;
      default:    rate = '0;
    endcase
  end

  // The carry out of the accumulator is the step; the level saturates both ways.
  assign sum       = (CNT_W+1)'(counter) + (CNT_W+1)'(rate);
  assign step      = sum[CNT_W];
  assign level_up  = (level == LVL_MAX) ? LVL_MAX : level + LVL_W'(1);
  assign level_dn  = (level == '0) ? '0 : level - LVL_W'(1);
  assign decayed   = step ? level_dn : level;
  assign hold_last = (HL_W'(hold) << HOLD_SHIFT) - HL_W'(1);

  // Event handling first; otherwise advance the phase (gate mode just holds).
  always_comb begin
    // NOTE: every output gets its hold value first so no path leaves one unassigned, which would infer a latch.
    state_next   = state;
    counter_next = counter;
    level_next   = level;
    if (ev == EV_OFF) begin
      state_next   = ST_IDLE;
      counter_next = '0;
      level_next   = '0;
    end else if (ev == EV_ON) begin
      counter_next = '0;
      if (adsr_en) begin
        state_next = ST_ATTACK;
        if (RETRIG != 0) level_next = '0;
      end else begin
        state_next = ST_SUSTAIN;
        level_next = LVL_MAX;
      end
    end else if (ev == EV_RELEASE) begin
      if (!adsr_en) begin
        state_next   = ST_IDLE;
        counter_next = '0;
        level_next   = '0;
      end else if (state != ST_IDLE) begin
        state_next   = ST_RELEASE;
        counter_next = '0;
      end
    end else if (adsr_en) begin
      case (state)
        ST_ATTACK: begin
          counter_next = sum[CNT_W-1:0];
          if (step) begin
            level_next = level_up;
            if (level_up == LVL_MAX) begin
              state_next   = (hold != '0) ? ST_HOLD : ST_DECAY;
              counter_next = '0;
            end
          end
        end
        ST_HOLD: begin
          if (HL_W'(counter) == hold_last) begin
            state_next   = ST_DECAY;
            counter_next = '0;
          end else begin
            counter_next = counter + CNT_W'(1);
          end
        end
        ST_DECAY: begin
          counter_next = sum[CNT_W-1:0];
          if (decayed <= sl) begin
            state_next   = ST_SUSTAIN;
            counter_next = '0;
            level_next   = sl;
          end else begin
            level_next = decayed;
          end
        end
        ST_SUSTAIN, ST_RELEASE: begin
          counter_next = sum[CNT_W-1:0];
          level_next   = decayed;
          if (decayed == '0) begin
            state_next   = ST_IDLE;
            counter_next = '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wts_adsr_envelope_generator_nch.sv
// N-channel ADSR envelope generator: per-channel phase/counter/level
// registers and sticky key flags around one shared update datapath,
// plus a registered, channel-tagged envelope output.
module wts_adsr_envelope_generator_nch
  import wts_adsr_pkg::*;
#(
  parameter int CH         = 5,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 20,
  parameter int LVL_W      = 7,
  parameter int HOLD_SHIFT = 8,
  parameter int RETRIG     = 0
) (
  input logic nreset,
  input logic clk,
  wts_adsr_envelope_generator_nch_if.slave bus
);

  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

  adsr_state_e      state_q [CH];
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [LVL_W-1:0] level_q [CH];
  logic [CH-1:0]    pend_on_q, pend_rel_q, pend_off_q;
  logic [CH-1:0]    pend_on_d, pend_rel_d, pend_off_d;
  logic [CH-1:0]    on_now, rel_now, off_now;

  logic             slot_vld;
  logic [SEL_W-1:0] sel;
  adsr_event_e      ev;
  adsr_state_e      state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [LVL_W-1:0] level_nx;

  logic [LVL_W-1:0] env_q;
  logic [IDX_W-1:0] env_ch_q;
  logic             env_vld_q;

  // Out-of-range slot numbers are idle slots; sel stays in range for the muxes.
  assign slot_vld = bus.active < IDX_W'(CH);
  assign sel      = slot_vld ? SEL_W'(bus.active) : '0;

  // A pulse arriving in the channel's own slot is acted on at once.
  assign on_now  = pend_on_q  | bus.key_on;
  assign rel_now = pend_rel_q | bus.key_release;
  assign off_now = pend_off_q | bus.key_off;
  assign ev      = pick_event(on_now[sel], rel_now[sel], off_now[sel]);

  wts_adsr_step #(
    .CNT_W      (CNT_W),
    .LVL_W      (LVL_W),
    .HOLD_SHIFT (HOLD_SHIFT),
    .RETRIG     (RETRIG)
  ) u_step (
    .state        (state_q[sel]),
    .counter      (cnt_q[sel]),
    .level        (level_q[sel]),
    .ev           (ev),
    .adsr_en      (bus.adsr_en),
    .ar           (bus.reg_ar[sel*8 +: 8]),
    .dr           (bus.reg_dr[sel*8 +: 8]),
    .sr           (bus.reg_sr[sel*8 +: 8]),
    .rr           (bus.reg_rr[sel*8 +: 8]),
    .hold         (bus.reg_hold[sel*8 +: 8]),
    .sl           (bus.reg_sl[sel*LVL_W +: LVL_W]),
    .state_next   (state_nx),
    .counter_next (cnt_nx),
    .level_next   (level_nx)
  );

  // Key flags stick every cycle; the serviced channel's flags are all consumed.
  always_comb begin
    pend_on_d  = on_now;
    pend_rel_d = rel_now;
    pend_off_d = off_now;
    if (slot_vld) begin
      pend_on_d[sel]  = 1'b0;
      pend_rel_d[sel] = 1'b0;
      pend_off_d[sel] = 1'b0;
    end
  end

  // Per-channel registers; only the serviced channel is written.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: these arrays are a few flops per channel, not a RAM, so they take the async reset.
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        level_q[i] <= '0;
      end
      pend_on_q  <= '0;
      pend_rel_q <= '0;
      pend_off_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pend_on_q  <= pend_on_d;
      pend_rel_q <= pend_rel_d;
      pend_off_q <= pend_off_d;
      if (slot_vld) begin
        state_q[sel] <= state_nx;
        cnt_q[sel]   <= cnt_nx;
        level_q[sel] <= level_nx;
      end
    end
  end

  // Output register: tagged level of the slot just serviced; idle slots hold it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      env_q     <= '0;
      env_ch_q  <= '0;
      env_vld_q <= 1'b0;
    end else begin
      env_vld_q <= slot_vld;
      if (slot_vld) begin
        env_q    <= level_nx;
        env_ch_q <= bus.active;
      end
    end
  end

  assign bus.envelope     = env_q;
  assign bus.envelope_ch  = env_ch_q;
  assign bus.envelope_vld = env_vld_q;

endmodule

// File: tb/tb_wts_adsr_envelope_generator_nch.sv
// Bench for the N-channel ADSR generator. Two instances share one stimulus:
// g_dut[0] uses HOLD_SHIFT=8/RETRIG=0, g_dut[1] uses HOLD_SHIFT=2/RETRIG=1.
// A behavioural model queues the expected output of every cycle.
module tb_wts_adsr_envelope_generator_nch;

  localparam int CH      = 5;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;
  localparam int LVL_W   = 7;
  localparam int NDUT    = 2;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int LMAX    = (1 << LVL_W) - 1;

  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4, S_HOLD = 5;

  typedef struct {
    int               dut;
    logic             vld;
    logic [IDX_W-1:0] ch;
    logic [LVL_W-1:0] env;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [IDX_W-1:0]    active;
  logic                adsr_en;
  logic [CH-1:0]       key_on, key_release, key_off;
  logic [CH*8-1:0]     reg_ar, reg_dr, reg_sr, reg_rr, reg_hold;
  logic [CH*LVL_W-1:0] reg_sl;

  logic [LVL_W-1:0] obs_env [NDUT];
  logic [IDX_W-1:0] obs_ch  [NDUT];
  logic             obs_vld [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wts_adsr_envelope_generator_nch_if #(.CH(CH), .IDX_W(IDX_W), .LVL_W(LVL_W)) bus ();
    assign bus.active      = active;
    assign bus.adsr_en     = adsr_en;
    assign bus.key_on      = key_on;
    assign bus.key_release = key_release;
    assign bus.key_off     = key_off;
    assign bus.reg_ar      = reg_ar;
    assign bus.reg_dr      = reg_dr;
    assign bus.reg_sr      = reg_sr;
    assign bus.reg_rr      = reg_rr;
    assign bus.reg_hold    = reg_hold;
    assign bus.reg_sl      = reg_sl;
    assign obs_env[g]      = bus.envelope;
    assign obs_ch[g]       = bus.envelope_ch;
    assign obs_vld[g]      = bus.envelope_vld;

    wts_adsr_envelope_generator_nch #(
      .CH(CH), .IDX_W(IDX_W), .CNT_W(CNT_W), .LVL_W(LVL_W),
      .HOLD_SHIFT((g == 0) ? 8 : 2), .RETRIG(g)
    ) u_dut (
      .nreset (nreset),
      .clk    (clk),
      .bus    (bus)
    );
  end

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  int m_st  [NDUT][CH];
  int m_cnt [NDUT][CH];
  int m_lvl [NDUT][CH];
  bit m_pon [NDUT][CH];
  bit m_prel[NDUT][CH];
  bit m_poff[NDUT][CH];
  int m_env [NDUT];
  int m_ch  [NDUT];

  int last_lvl [NDUT][CH];
  int peak_cnt [NDUT];

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected)
      else begin
        n_err++;
        $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < CH; c++) begin
        m_st[d][c] = S_IDLE; m_cnt[d][c] = 0; m_lvl[d][c] = 0;
        m_pon[d][c] = 0; m_prel[d][c] = 0; m_poff[d][c] = 0;
      end
      m_env[d] = 0;
      m_ch[d]  = 0;
    end
  endtask

  // Spec-level model of one cycle for instance d; pushes the expected output.
  task automatic model_cycle(input int d);
    int   c, st, cnt, lvl, acc, rate, sl, hl, hs;
    bit   on, rel, off;
    exp_t e;
    hs = (d == 0) ? 8 : 2;
    for (int i = 0; i < CH; i++) begin
      if (key_on[i])      m_pon[d][i]  = 1;
      if (key_release[i]) m_prel[d][i] = 1;
      if (key_off[i])     m_poff[d][i] = 1;
    end
    e.dut = d;
    if (int'(active) >= CH) begin
      e.vld = 1'b0;
      e.ch  = IDX_W'(m_ch[d]);
      e.env = LVL_W'(m_env[d]);
    end else begin
      c   = int'(active);
      st  = m_st[d][c]; cnt = m_cnt[d][c]; lvl = m_lvl[d][c];
      on  = m_pon[d][c]; rel = m_prel[d][c]; off = m_poff[d][c];
      m_pon[d][c] = 0; m_prel[d][c] = 0; m_poff[d][c] = 0;
      sl  = int'(reg_sl[c*LVL_W +: LVL_W]);
      if (off) begin
        st = S_IDLE; lvl = 0; cnt = 0;
      end else if (on) begin
        cnt = 0;
        if (adsr_en) begin
          st = S_ATTACK;
          if (d == 1) lvl = 0;
        end else begin
          st = S_SUSTAIN; lvl = LMAX;
        end
      end else if (rel) begin
        if (!adsr_en) begin
          st = S_IDLE; lvl = 0; cnt = 0;
        end else if (st != S_IDLE) begin
          st = S_RELEASE; cnt = 0;
        end
      end else if (adsr_en && st == S_HOLD) begin
        hl = (int'(reg_hold[c*8 +: 8]) << hs) - 1;
        if (cnt == hl) begin
          st = S_DECAY; cnt = 0;
        end else begin
          cnt = (cnt + 1) % CNT_MOD;
        end
      end else if (adsr_en && st != S_IDLE) begin
        case (st)
          S_ATTACK:  rate = int'(reg_ar[c*8 +: 8]);
          S_DECAY:   rate = int'(reg_dr[c*8 +: 8]);
          S_SUSTAIN: rate = int'(reg_sr[c*8 +: 8]);
          default:   rate = int'(reg_rr[c*8 +: 8]);
        endcase
        acc = cnt + rate;
        cnt = acc % CNT_MOD;
        if (st == S_ATTACK) begin
          if (acc >= CNT_MOD) begin
            if (lvl < LMAX) lvl++;
            if (lvl == LMAX) begin
              st  = (reg_hold[c*8 +: 8] != 0) ? S_HOLD : S_DECAY;
              cnt = 0;
            end
          end
        end else begin
          if (acc >= CNT_MOD && lvl > 0) lvl--;
          if (st == S_DECAY) begin
            if (lvl <= sl) begin
              lvl = sl; st = S_SUSTAIN; cnt = 0;
            end
          end else if (lvl == 0) begin
            st = S_IDLE; cnt = 0;
          end
        end
      end
      m_st[d][c] = st; m_cnt[d][c] = cnt; m_lvl[d][c] = lvl;
      m_env[d] = lvl;
      m_ch[d]  = c;
      e.vld = 1'b1;
      e.ch  = IDX_W'(c);
      e.env = LVL_W'(lvl);
    end
    sb.push_back(e);
  endtask

  // Pop one expectation per instance and compare the full output triple.
  task automatic check_outputs();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $error("FAIL sb_empty dut%0d: observed empty queue, expected an entry", d);
      end else begin
        e = sb.pop_front();
        assert ({obs_vld[d], obs_ch[d], obs_env[d]} === {e.vld, e.ch, e.env})
          else begin
            n_err++;
            $error("FAIL sb dut%0d: observed vld=%0b ch=%0d env=%0d, expected vld=%0b ch=%0d env=%0d",
                   e.dut, obs_vld[d], obs_ch[d], obs_env[d], e.vld, e.ch, e.env);
          end
      end
      if (obs_vld[d] === 1'b1) begin
        last_lvl[d][int'(obs_ch[d])] = int'(obs_env[d]);
        if (obs_ch[d] == IDX_W'(1) && obs_env[d] == LVL_W'(LMAX)) peak_cnt[d]++;
      end
    end
  endtask

  // One clock: model, edge, sample on the falling edge, then drop key pulses.
  task automatic cycle();
    for (int d = 0; d < NDUT; d++) model_cycle(d);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    key_on = '0; key_release = '0; key_off = '0;
  endtask

  task automatic run_slots(input int n);
    for (int k = 0; k < n; k++) begin
      cycle();
      active = (int'(active) >= CH) ? '0 : active + IDX_W'(1);
    end
  endtask

  task automatic run_rounds(input int n);
    run_slots(n * (CH + 1));
  endtask

  task automatic goto_slot(input int a);
    for (int k = 0; k <= CH && int'(active) != a; k++) run_slots(1);
  endtask

  task automatic set_ch(input int c, input int ar, input int dr, input int sl,
                        input int sr, input int rr, input int hold);
    reg_ar[c*8 +: 8]         = 8'(ar);
    reg_dr[c*8 +: 8]         = 8'(dr);
    reg_sr[c*8 +: 8]         = 8'(sr);
    reg_rr[c*8 +: 8]         = 8'(rr);
    reg_hold[c*8 +: 8]       = 8'(hold);
    reg_sl[c*LVL_W +: LVL_W] = LVL_W'(sl);
  endtask

  task automatic check_level(input string tag, input int c, input int exp0, input int exp1);
    check({tag, "_dut0"}, last_lvl[0][c], exp0);
    check({tag, "_dut1"}, last_lvl[1][c], exp1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset = 1'b0; active = '0; adsr_en = 1'b1;
    key_on = '0; key_release = '0; key_off = '0;
    reg_ar = '0; reg_dr = '0; reg_sr = '0; reg_rr = '0; reg_hold = '0; reg_sl = '0;
    model_reset();
    for (int d = 0; d < NDUT; d++) begin
      peak_cnt[d] = 0;
      for (int c = 0; c < CH; c++) last_lvl[d][c] = -1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("reset_env", int'(obs_env[d]), 0);
      check("reset_ch",  int'(obs_ch[d]),  0);
      check("reset_vld", int'(obs_vld[d]), 0);
    end
    nreset = 1'b1;

    //     ch  AR   DR   SL  SR  RR   HOLD
    set_ch(0, 255, 255, 40,  0, 255, 0);
    set_ch(1, 255, 255, 20,  0, 255, 1);
    set_ch(2, 255,   0,  0,  0,   0, 0);
    set_ch(3, 255, 255, 60,  0, 255, 0);
    set_ch(4, 255, 255, 50,  0,   0, 0);

    // Ch0 keyed in its own slot, ch2 keyed outside its slot (must stay pending).
    goto_slot(0);
    key_on = 5'b00101;
    run_slots(1);
    key_on = 5'b11010;
    run_slots(1);

    run_rounds(140);
    check_level("attack_ch2_top", 2, LMAX, LMAX);

    run_rounds(280);
    check_level("decay_ch0_sl", 0, 40, 40);
    check_level("decay_ch3_sl", 3, 60, 60);
    check_level("decay_ch4_sl", 4, 50, 50);
    check_level("decay_dr0_ch2", 2, LMAX, LMAX);
    check("hold_peak_shift8", peak_cnt[0], 258);
    check("hold_peak_shift2", peak_cnt[1], 6);

    // Off and on together: off wins.
    goto_slot(0);
    key_on[3] = 1'b1; key_off[3] = 1'b1;
    run_rounds(1);
    check_level("on_off_ch3", 3, 0, 0);
    goto_slot(3);
    key_release[3] = 1'b1;
    run_rounds(2);
    check_level("release_idle_ch3", 3, 0, 0);

    // Release with RR=0 parks ch4 at 50, then retrigger.
    goto_slot(0);
    key_release[4] = 1'b1;
    run_rounds(1);
    check_level("release_hold_ch4", 4, 50, 50);
    goto_slot(0);
    key_on[4] = 1'b1;
    run_rounds(1);
    check_level("retrig_ch4", 4, 50, 0);
    check_level("sustain_ch0_still", 0, 40, 40);

    // Gate mode.
    adsr_en = 1'b0;
    goto_slot(1);
    key_on[0] = 1'b1;
    run_rounds(1);
    check_level("gate_on_ch0", 0, LMAX, LMAX);
    goto_slot(1);
    key_release[0] = 1'b1;
    run_rounds(1);
    check_level("gate_rel_ch0", 0, 0, 0);

    // Asynchronous reset in the middle of an attack.
    adsr_en = 1'b1;
    goto_slot(1);
    key_on[0] = 1'b1;
    run_rounds(60);
    check("mid_attack_ch0_nonzero", int'(last_lvl[0][0] > 0), 1);
    #2 nreset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("async_rst_env", int'(obs_env[d]), 0);
      check("async_rst_ch",  int'(obs_ch[d]),  0);
      check("async_rst_vld", int'(obs_vld[d]), 0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    run_rounds(2);
    check_level("after_rst_ch0", 0, 0, 0);
    check_level("after_rst_ch2", 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
